// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, aligner FSM states and the 10b->8b helpers.
package tmds_pkg;

    localparam logic [9:0] TOK_C00 = 10'h354;
    localparam logic [9:0] TOK_C01 = 10'h0AB;
    localparam logic [9:0] TOK_C10 = 10'h154;
    localparam logic [9:0] TOK_C11 = 10'h2AB;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        SETTLE = 2'd2,
        LOCKED = 2'd3
    } align_state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] ctrl;
    } tok_match_t;

    function automatic tok_match_t tok_match(input logic [9:0] w);
        tok_match_t m;
        m.valid = 1'b1;
        m.ctrl  = 2'b00;
        case (w)
            TOK_C00: m.ctrl = 2'b00;
            TOK_C01: m.ctrl = 2'b01;
            TOK_C10: m.ctrl = 2'b10;
            TOK_C11: m.ctrl = 2'b11;
            default: m.valid = 1'b0;
        endcase
        return m;
    endfunction

    // Undo the optional inversion (q[9]) then the XOR/XNOR chain (q[8]).
    function automatic logic [7:0] tmds_decode(input logic [9:0] q);
        logic [7:0] d;
        logic [7:0] o;
        d    = q[9] ? ~q[7:0] : q[7:0];
        o    = '0;
        o[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return o;
    endfunction

endpackage

// File: rtl/tmds_decoder.sv
// Token match and registered 10b->8b decode; outputs forced to zero unless lock_en.
module tmds_decoder
    import tmds_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] data_in,
    input  logic       lock_en,
    output logic       is_token_c,
    output logic [7:0] pixel_out,
    output logic [1:0] ctrl_out,
    output logic       de_out
);

    logic [9:0] data_d, data_q;
    logic [7:0] pixel_d, pixel_q;
    logic [1:0] ctrl_d, ctrl_q;
    logic       de_d, de_q;
    tok_match_t in_match, q_match;

    assign in_match   = tok_match(data_in);
    assign q_match    = tok_match(data_q);
    assign is_token_c = in_match.valid;

    always_comb begin
        data_d  = data_in;
        pixel_d = '0;
        ctrl_d  = '0;
        de_d    = 1'b0;
        if (lock_en) begin
            if (q_match.valid) begin
                ctrl_d = q_match.ctrl;
            end else begin
                de_d    = 1'b1;
                ctrl_d  = ctrl_q;
                pixel_d = tmds_decode(data_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            pixel_q <= '0;
            ctrl_q  <= '0;
            de_q    <= 1'b0;
        end else begin
            data_q  <= data_d;
            pixel_q <= pixel_d;
            ctrl_q  <= ctrl_d;
            de_q    <= de_d;
        end
    end

    assign pixel_out = pixel_q;
    assign ctrl_out  = ctrl_q;
    assign de_out    = de_q;

endmodule

// File: rtl/tmds_channel_aligner.sv
// Per-channel TMDS word aligner: slips the deserializer until control tokens line up, then decodes.
module tmds_channel_aligner
    import tmds_pkg::*;
#(
    parameter int unsigned SEARCH_CYCLES = 2048,
    parameter int unsigned LOCK_TOKENS   = 16,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk_1x_in,
    input  logic       reset_n_in,
    input  logic [9:0] deser_data_in,
    output logic       bit_slip_out,
    output logic       locked_out,
    output logic [3:0] slip_cnt_out,
    output logic [7:0] pixel_out,
    output logic [1:0] ctrl_out,
    output logic       de_out
);

    localparam int unsigned WIN_W = (SEARCH_CYCLES > 1) ? $clog2(SEARCH_CYCLES) : 1;
    localparam int unsigned TOK_W = $clog2(LOCK_TOKENS + 1);
    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    align_state_t     state_d, state_q;
    logic [WIN_W-1:0] win_d, win_q;
    logic [TOK_W-1:0] tok_d, tok_q, tok_sum;
    logic [SET_W-1:0] set_d, set_q;
    logic [3:0]       slip_cnt_d, slip_cnt_q;
    logic             bit_slip_d, bit_slip_q;
    logic             locked_d, locked_q;
    logic             is_token_c;
    logic             win_end_c;

    tmds_decoder u_decoder (
        .clk        (clk_1x_in),
        .rst_n      (reset_n_in),
        .data_in    (deser_data_in),
        .lock_en    (state_q == LOCKED),
        .is_token_c (is_token_c),
        .pixel_out  (pixel_out),
        .ctrl_out   (ctrl_out),
        .de_out     (de_out)
    );

    assign tok_sum   = tok_q + TOK_W'(is_token_c);
    assign win_end_c = (win_q == WIN_W'(SEARCH_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        tok_d      = tok_q;
        set_d      = set_q;
        slip_cnt_d = slip_cnt_q;
        case (state_q)
            SEARCH: begin
                win_d = win_q + WIN_W'(1);
                tok_d = tok_sum;
                // Reaching the token target takes priority over window expiry.
                if (tok_sum >= TOK_W'(LOCK_TOKENS)) begin
                    state_d = LOCKED;
                    win_d   = '0;
                    tok_d   = '0;
                end else if (win_end_c) begin
                    state_d    = SLIP;
                    win_d      = '0;
                    tok_d      = '0;
                    slip_cnt_d = (slip_cnt_q == 4'd9) ? 4'd0 : slip_cnt_q + 4'd1;
                end
            end
            SLIP: begin
                state_d = SETTLE;
                set_d   = '0;
            end
            SETTLE: begin
                if (set_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d = SEARCH;
                    set_d   = '0;
                    win_d   = '0;
                    tok_d   = '0;
                end else begin
                    set_d = set_q + SET_W'(1);
                end
            end
            LOCKED: begin
                if (is_token_c) begin
                    win_d = '0;
                end else if (win_end_c) begin
                    state_d = SEARCH;
                    win_d   = '0;
                    tok_d   = '0;
                end else begin
                    win_d = win_q + WIN_W'(1);
                end
            end
            default: state_d = SEARCH;
        endcase
        // Pulse coincides with the SLIP state; lock indication trails the state by one edge.
        bit_slip_d = (state_d == SLIP);
        locked_d   = (state_q == LOCKED);
    end

    always_ff @(posedge clk_1x_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q    <= SEARCH;
            win_q      <= '0;
            tok_q      <= '0;
            set_q      <= '0;
            slip_cnt_q <= '0;
            bit_slip_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            tok_q      <= tok_d;
            set_q      <= set_d;
            slip_cnt_q <= slip_cnt_d;
            bit_slip_q <= bit_slip_d;
            locked_q   <= locked_d;
        end
    end

    assign bit_slip_out = bit_slip_q;
    assign locked_out   = locked_q;
    assign slip_cnt_out = slip_cnt_q;

endmodule

// File: tb/tb_tmds_channel_aligner.sv
// Bench for tmds_channel_aligner with a rotating-word deserializer model and a decode scoreboard.
module tb_tmds_channel_aligner;

    logic       clk_1x_in = 1'b0;
    logic       reset_n_in;
    logic [9:0] deser_data_in;
    logic       bit_slip_out;
    logic       locked_out;
    logic [3:0] slip_cnt_out;
    logic [7:0] pixel_out;
    logic [1:0] ctrl_out;
    logic       de_out;

    tmds_channel_aligner #(
        .SEARCH_CYCLES (64),
        .LOCK_TOKENS   (16),
        .SETTLE_CYCLES (4)
    ) dut (
        .clk_1x_in     (clk_1x_in),
        .reset_n_in    (reset_n_in),
        .deser_data_in (deser_data_in),
        .bit_slip_out  (bit_slip_out),
        .locked_out    (locked_out),
        .slip_cnt_out  (slip_cnt_out),
        .pixel_out     (pixel_out),
        .ctrl_out      (ctrl_out),
        .de_out        (de_out)
    );

    always #5 clk_1x_in = ~clk_1x_in;

    typedef struct {
        logic [9:0] word;
        logic [7:0] pix;
        logic [1:0] ctrl;
        logic       de;
    } vec_t;

    typedef struct {
        int         idx;
        int         due;
        logic [7:0] pix;
        logic [1:0] ctrl;
        logic       de;
    } exp_t;

    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    int         off    = 0;
    int         slips  = 0;
    int         dbl    = 0;
    logic       prev_slip = 1'b0;
    logic [9:0] base;
    exp_t       sb[$];
    vec_t       vecs[10];

    function automatic logic [9:0] rotr(input logic [9:0] w, input int k);
        logic [19:0] t;
        t = {w, w};
        return t[k +: 10];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample away from the edge, let the deserializer model react to slip pulses.
    task automatic step();
        @(posedge clk_1x_in);
        #1;
        cyc++;
        if (bit_slip_out) begin
            slips++;
            if (prev_slip) dbl++;
            off = (off + 1) % 10;
        end
        prev_slip     = bit_slip_out;
        deser_data_in = rotr(base, off);
    endtask

    task automatic do_reset(input logic [9:0] w, input int start_off);
        reset_n_in    = 1'b0;
        base          = w;
        off           = start_off;
        slips         = 0;
        prev_slip     = 1'b0;
        deser_data_in = rotr(base, off);
        repeat (3) @(posedge clk_1x_in);
        #1;
        chk("reset_outputs", int'({bit_slip_out, locked_out, slip_cnt_out, pixel_out, ctrl_out, de_out}), 0);
        reset_n_in = 1'b1;
        cyc        = 0;
    endtask

    initial begin
        int   last_slip;
        int   nslip;
        int   slips_before;
        exp_t e;

        vecs[0] = '{10'h100, 8'h00, 2'b00, 1'b1};
        vecs[1] = '{10'h1FF, 8'h01, 2'b00, 1'b1};
        vecs[2] = '{10'h2FF, 8'hFE, 2'b00, 1'b1};
        vecs[3] = '{10'h2AB, 8'h00, 2'b11, 1'b0};
        vecs[4] = '{10'h155, 8'hFF, 2'b11, 1'b1};
        vecs[5] = '{10'h000, 8'hFE, 2'b11, 1'b1};
        vecs[6] = '{10'h154, 8'h00, 2'b10, 1'b0};
        vecs[7] = '{10'h3AA, 8'hFF, 2'b10, 1'b1};
        vecs[8] = '{10'h0AB, 8'h00, 2'b01, 1'b0};
        vecs[9] = '{10'h354, 8'h00, 2'b00, 1'b0};

        // Aligned lock: 16th token sampled at edge 16, locked_out after edge 17.
        do_reset(10'h354, 0);
        for (int k = 1; k <= 17; k++) begin
            step();
            if (k == 16) chk("aligned_not_early", int'(locked_out), 0);
        end
        chk("aligned_locked", int'(locked_out), 1);
        chk("aligned_ctrl", int'(ctrl_out), 0);
        chk("aligned_de", int'(de_out), 0);
        chk("aligned_slip_cnt", int'(slip_cnt_out), 0);
        chk("aligned_no_slips", slips, 0);

        // Decode vectors through the scoreboard; each result due two samples after driving.
        for (int i = 0; i < 12; i++) begin
            if (i < 10) begin
                base          = vecs[i].word;
                deser_data_in = base;
                sb.push_back('{i, cyc + 2, vecs[i].pix, vecs[i].ctrl, vecs[i].de});
            end else begin
                base          = 10'h354;
                deser_data_in = base;
            end
            step();
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk($sformatf("dec%0d_pixel", e.idx), int'(pixel_out), int'(e.pix));
                chk($sformatf("dec%0d_ctrl", e.idx), int'(ctrl_out), int'(e.ctrl));
                chk($sformatf("dec%0d_de", e.idx), int'(de_out), int'(e.de));
            end
        end
        chk("dec_scoreboard_drained", sb.size(), 0);

        // Loss of lock: 64 data-only samples, locked_out falls on the following edge.
        slips_before  = slips;
        base          = 10'h100;
        deser_data_in = base;
        for (int k = 1; k <= 65; k++) begin
            step();
            if (k == 64) begin
                chk("lol_still_locked", int'(locked_out), 1);
                chk("lol_de_before", int'(de_out), 1);
            end
        end
        chk("lol_unlocked", int'(locked_out), 0);
        chk("lol_outputs_zero", int'({pixel_out, ctrl_out, de_out}), 0);
        base          = 10'h354;
        deser_data_in = base;
        for (int k = 0; k < 40 && !locked_out; k++) step();
        chk("lol_relocked", int'(locked_out), 1);
        chk("lol_no_slip_pulse", slips - slips_before, 0);
        chk("lol_slip_cnt", int'(slip_cnt_out), 0);

        // Misaligned by 3 bits: 7 slips spaced >= 68 cycles, then lock.
        do_reset(10'h354, 3);
        last_slip = 0;
        nslip     = 0;
        for (int k = 0; k < 1200 && !locked_out; k++) begin
            step();
            if (bit_slip_out) begin
                if (nslip > 0) chk("mis_slip_spacing", int'(cyc - last_slip >= 68), 1);
                last_slip = cyc;
                nslip++;
            end
        end
        chk("mis_locked", int'(locked_out), 1);
        chk("mis_slip_count", nslip, 7);
        chk("mis_slip_cnt_out", int'(slip_cnt_out), 7);
        chk("mis_ctrl", int'(ctrl_out), 0);

        // Wrap: never-locking data stream, slip_cnt_out 1..9,0,1 over 11 slips.
        do_reset(10'h000, 0);
        nslip = 0;
        for (int k = 0; k < 1000 && nslip < 11; k++) begin
            step();
            if (bit_slip_out) begin
                chk($sformatf("wrap_slip%0d", nslip + 1), int'(slip_cnt_out), (nslip + 1) % 10);
                nslip++;
            end
        end
        chk("wrap_slip_total", nslip, 11);
        chk("wrap_never_locked", int'(locked_out), 0);

        // Reset while the slip pulse is high: everything clears asynchronously.
        for (int k = 0; k < 100 && !bit_slip_out; k++) step();
        chk("rst_slip_seen", int'(bit_slip_out), 1);
        reset_n_in = 1'b0;
        #1;
        chk("rst_async_clear", int'({bit_slip_out, locked_out, slip_cnt_out, pixel_out, ctrl_out, de_out}), 0);
        repeat (2) @(posedge clk_1x_in);
        #1;
        reset_n_in = 1'b1;
        prev_slip  = 1'b0;
        step();
        chk("rst_slip_cnt_after", int'(slip_cnt_out), 0);
        chk("rst_no_pulse_after", int'(bit_slip_out), 0);

        chk("no_double_pulse", dbl, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
